decode_regfile: RTL and testbench

Decode and operand-fetch stage of the RV32I core, sitting directly upstream of the ALU. It accepts one instruction per cycle over a valid/ready handshake and decodes OP and OP-IMM formats. It reads a 32x32 integer register file and presents registered operands, immediate, funct3, funct7 and the register/immediate select to the ALU one cycle later. It also owns the register-file write port that the write-back path drives with the ALU result.

---
 rtl/decode_regfile_if.sv | 35 +++
 rtl/decode_regfile.sv | 143 ++++++++++++++
 tb/tb_decode_regfile.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_regfile_if.sv
// Handshake, decoded-bundle and write-back signals between fetch, the
// decode/operand-fetch stage and the ALU/write-back path.
interface decode_regfile_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rs1;
   logic [31:0] out_rs2;
   logic [31:0] out_imm;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic        out_isALUreg;
   logic [4:0]  out_rd;
   logic        out_wb_en;
   logic        out_illegal;
   logic [31:0] out_pc;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (
      output in_valid, in_instr, in_pc, out_ready, wb_en, wb_rd, wb_data,
      input  in_ready, out_valid, out_rs1, out_rs2, out_imm, out_funct3,
             out_funct7, out_isALUreg, out_rd, out_wb_en, out_illegal, out_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready, wb_en, wb_rd, wb_data,
      output in_ready, out_valid, out_rs1, out_rs2, out_imm, out_funct3,
             out_funct7, out_isALUreg, out_rd, out_wb_en, out_illegal, out_pc
   );
endinterface

// File: rtl/decode_regfile.sv
// RV32I decode and operand-fetch stage: decodes OP/OP-IMM, reads the 32x32
// register file with write-back bypass, and presents a registered bundle to the ALU.
module decode_regfile #(
   parameter int unsigned XLEN       = 32,
   parameter bit          RESET_REGS = 1'b1
) (
   input logic            clk,
   input logic            rst,
   decode_regfile_if.slave bus
);
   localparam int unsigned NREGS     = 32;
   localparam logic [6:0]  OPC_OP    = 7'b0110011;
   localparam logic [6:0]  OPC_OPIMM = 7'b0010011;

   logic [XLEN-1:0] r_regs [NREGS];

   logic            r_valid;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_pc;
   logic [2:0]      r_funct3;
   logic [6:0]      r_funct7;
   logic            r_is_alu_reg;
   logic [4:0]      r_rd;
   logic            r_wb_en;
   logic            r_illegal;
   logic [4:0]      r_rs1_idx;
   logic [4:0]      r_rs2_idx;

   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [2:0]      w_funct3;
   logic [4:0]      w_rs1_idx;
   logic [4:0]      w_rs2_idx;
   logic            w_is_op;
   logic            w_is_opimm;
   logic            w_is_shift;
   logic [XLEN-1:0] w_imm;
   logic [6:0]      w_funct7;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;
   logic            w_accept;
   logic            w_consume;
   logic            w_wb_live;

   assign w_opcode   = bus.in_instr[6:0];
   assign w_rd       = bus.in_instr[11:7];
   assign w_funct3   = bus.in_instr[14:12];
   assign w_rs1_idx  = bus.in_instr[19:15];
   assign w_rs2_idx  = bus.in_instr[24:20];
   assign w_is_op    = (w_opcode == OPC_OP);
   assign w_is_opimm = (w_opcode == OPC_OPIMM);
   assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

   assign bus.in_ready = !r_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_consume    = r_valid && bus.out_ready;
   assign w_wb_live    = bus.wb_en && (bus.wb_rd != 5'd0);

   // Non-OP opcodes decode as OP-IMM; funct7 is only exposed where it means something.
   always_comb begin
      w_imm    = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
      w_funct7 = 7'd0;
      if (w_is_op) begin
         w_imm    = '0;
         w_funct7 = bus.in_instr[31:25];
      end else if (w_is_shift) begin
         w_imm    = XLEN'(bus.in_instr[24:20]);
         w_funct7 = bus.in_instr[31:25];
      end
   end

   // Operand read with same-cycle write-back bypass; x0 is hardwired to zero.
   always_comb begin
      w_rs1_val = r_regs[w_rs1_idx];
      w_rs2_val = r_regs[w_rs2_idx];
      if (w_wb_live && (bus.wb_rd == w_rs1_idx)) w_rs1_val = bus.wb_data;
      if (w_wb_live && (bus.wb_rd == w_rs2_idx)) w_rs2_val = bus.wb_data;
      if (w_rs1_idx == 5'd0) w_rs1_val = '0;
      if (w_rs2_idx == 5'd0) w_rs2_val = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (RESET_REGS) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         end
      end else if (w_wb_live) begin
         r_regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Output bundle: accept beats held-operand refresh since the held bundle is leaving.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_imm        <= '0;
         r_pc         <= '0;
         r_funct3     <= 3'd0;
         r_funct7     <= 7'd0;
         r_is_alu_reg <= 1'b0;
         r_rd         <= 5'd0;
         r_wb_en      <= 1'b0;
         r_illegal    <= 1'b0;
         r_rs1_idx    <= 5'd0;
         r_rs2_idx    <= 5'd0;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_rs1        <= w_rs1_val;
         r_rs2        <= w_rs2_val;
         r_imm        <= w_imm;
         r_pc         <= bus.in_pc;
         r_funct3     <= w_funct3;
         r_funct7     <= w_funct7;
         r_is_alu_reg <= w_is_op;
         r_rd         <= w_rd;
         r_wb_en      <= (w_is_op || w_is_opimm) && (w_rd != 5'd0);
         r_illegal    <= !(w_is_op || w_is_opimm);
         r_rs1_idx    <= w_rs1_idx;
         r_rs2_idx    <= w_rs2_idx;
      end else if (w_consume) begin
         r_valid <= 1'b0;
      end else if (r_valid) begin
         if (w_wb_live && (bus.wb_rd == r_rs1_idx)) r_rs1 <= bus.wb_data;
         if (w_wb_live && (bus.wb_rd == r_rs2_idx)) r_rs2 <= bus.wb_data;
      end
   end

   assign bus.out_valid    = r_valid;
   assign bus.out_rs1      = r_rs1;
   assign bus.out_rs2      = r_rs2;
   assign bus.out_imm      = r_imm;
   assign bus.out_pc       = r_pc;
   assign bus.out_funct3   = r_funct3;
   assign bus.out_funct7   = r_funct7;
   assign bus.out_isALUreg = r_is_alu_reg;
   assign bus.out_rd       = r_rd;
   assign bus.out_wb_en    = r_wb_en;
   assign bus.out_illegal  = r_illegal;
endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: decode vector table, directed hazard/stall/reset
// sequences, and random traffic against an architectural reference model.
module tb_decode_regfile;
   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        isreg;
      logic [4:0]  rd;
      logic        wben;
      logic        ill;
   } bundle_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        isreg;
      logic [4:0]  rd;
      logic        wben;
      logic        ill;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   decode_regfile_if bus ();

   decode_regfile #(.XLEN(32), .RESET_REGS(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: architectural registers plus the held bundle.
   logic [31:0] m_regs [32];
   logic        m_valid = 1'b0;
   bundle_t     m_b = '0;
   logic [4:0]  m_i1 = 5'd0;
   logic [4:0]  m_i2 = 5'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   function automatic bundle_t act_bundle();
      bundle_t b;
      b.rs1 = bus.out_rs1;       b.rs2 = bus.out_rs2;
      b.imm = bus.out_imm;       b.pc  = bus.out_pc;
      b.f3  = bus.out_funct3;    b.f7  = bus.out_funct7;
      b.isreg = bus.out_isALUreg; b.rd = bus.out_rd;
      b.wben  = bus.out_wb_en;    b.ill = bus.out_illegal;
      return b;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
      if (idx == 5'd0) return 32'd0;
      if (we && wrd == idx) return wd;
      return m_regs[idx];
   endfunction

   function automatic bundle_t m_decode(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
      bundle_t b;
      b.rs1 = m_read(instr[19:15], we, wrd, wd);
      b.rs2 = m_read(instr[24:20], we, wrd, wd);
      b.pc  = pc;
      b.f3  = instr[14:12];
      b.rd  = instr[11:7];
      if (instr[6:0] == 7'h33) begin
         b.isreg = 1'b1; b.ill = 1'b0; b.imm = 32'd0; b.f7 = instr[31:25];
         b.wben  = (b.rd != 5'd0);
      end else begin
         b.isreg = 1'b0;
         b.ill   = (instr[6:0] != 7'h13);
         b.wben  = !b.ill && (b.rd != 5'd0);
         if (b.f3 == 3'd1 || b.f3 == 3'd5) begin
            b.imm = {27'd0, instr[24:20]};
            b.f7  = instr[31:25];
         end else begin
            b.imm = {{20{instr[31]}}, instr[31:20]};
            b.f7  = 7'd0;
         end
      end
      return b;
   endfunction

   // One clock: drive at negedge, predict, then compare #1 after the rising edge.
   task automatic cyc(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic r);
      bundle_t a;
      bus.in_valid = v;  bus.in_instr = instr; bus.in_pc = pc;
      bus.out_ready = ordy;
      bus.wb_en = we;    bus.wb_rd = wrd;      bus.wb_data = wd;
      rst = r;
      #1;
      checkb("in_ready", bus.in_ready, !m_valid || ordy);
      if (r) begin
         m_valid = 1'b0; m_b = '0; m_i1 = 5'd0; m_i2 = 5'd0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      end else begin
         if (v && (!m_valid || ordy)) begin
            m_b = m_decode(instr, pc, we, wrd, wd);
            m_valid = 1'b1;
            m_i1 = instr[19:15];
            m_i2 = instr[24:20];
         end else if (m_valid && ordy) begin
            m_valid = 1'b0;
         end else if (m_valid) begin
            if (we && wrd != 5'd0 && wrd == m_i1) m_b.rs1 = wd;
            if (we && wrd != 5'd0 && wrd == m_i2) m_b.rs2 = wd;
         end
         if (we && wrd != 5'd0) m_regs[wrd] = wd;
      end
      @(posedge clk);
      #1;
      checkb("out_valid", bus.out_valid, m_valid);
      a = act_bundle();
      total++;
      if (a !== m_b) begin
         bad++;
         $display("FAIL bundle actual=%h required=%h", a, m_b);
      end
      @(negedge clk);
   endtask

   vec_t        vecs [8];
   logic [31:0] ins;
   int          sel;

   initial begin
      vecs[0] = '{32'hFFB00093, 32'hFFFFFFFB, 7'h00, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0}; // addi x1,x0,-5
      vecs[1] = '{32'h40310233, 32'h00000000, 7'h20, 3'd0, 1'b1, 5'd4, 1'b1, 1'b0}; // sub x4,x2,x3
      vecs[2] = '{32'h40315293, 32'h00000003, 7'h20, 3'd5, 1'b0, 5'd5, 1'b1, 1'b0}; // srai x5,x2,3
      vecs[3] = '{32'h01F11293, 32'h0000001F, 7'h00, 3'd1, 1'b0, 5'd5, 1'b1, 1'b0}; // slli x5,x2,31
      vecs[4] = '{32'h008000EF, 32'h00000008, 7'h00, 3'd0, 1'b0, 5'd1, 1'b0, 1'b1}; // jal x1,8
      vecs[5] = '{32'h00000013, 32'h00000000, 7'h00, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0}; // nop
      vecs[6] = '{32'hFFF0F493, 32'hFFFFFFFF, 7'h00, 3'd7, 1'b0, 5'd9, 1'b1, 1'b0}; // andi x9,x1,-1
      vecs[7] = '{32'h40008093, 32'h00000400, 7'h00, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0}; // addi x1,x1,0x400

      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
      bus.wb_en = 1'b0;    bus.wb_rd = 5'd0;     bus.wb_data = 32'd0;
      rst = 1'b1;
      @(negedge clk);

      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      checkb("rst_valid", bus.out_valid, 1'b0);
      checkb("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_imm", bus.out_imm, 32'd0);
      check("rst_pc", bus.out_pc, 32'd0);

      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, vecs[k].instr, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
         checkb($sformatf("v%0d_valid", k), bus.out_valid, 1'b1);
         check($sformatf("v%0d_imm", k), bus.out_imm, vecs[k].imm);
         check($sformatf("v%0d_funct7", k), 32'(bus.out_funct7), 32'(vecs[k].f7));
         check($sformatf("v%0d_funct3", k), 32'(bus.out_funct3), 32'(vecs[k].f3));
         checkb($sformatf("v%0d_isreg", k), bus.out_isALUreg, vecs[k].isreg);
         check($sformatf("v%0d_rd", k), 32'(bus.out_rd), 32'(vecs[k].rd));
         checkb($sformatf("v%0d_wben", k), bus.out_wb_en, vecs[k].wben);
         checkb($sformatf("v%0d_illegal", k), bus.out_illegal, vecs[k].ill);
      end

      // sub x4,x2,x3 after writing its sources
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd2, 32'h1234, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd3, 32'h10, 1'b0);
      cyc(1'b1, 32'h40310233, 32'h200, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("sub_rs1", bus.out_rs1, 32'h1234);
      check("sub_rs2", bus.out_rs2, 32'h10);
      check("sub_funct7", 32'(bus.out_funct7), 32'h20);
      checkb("sub_isreg", bus.out_isALUreg, 1'b1);

      // same-cycle write-back bypass: add x7,x6,x6
      cyc(1'b1, 32'h006303B3, 32'h204, 1'b1, 1'b1, 5'd6, 32'hDEADBEEF, 1'b0);
      check("byp_rs1", bus.out_rs1, 32'hDEADBEEF);
      check("byp_rs2", bus.out_rs2, 32'hDEADBEEF);

      // stall refresh: add x8,x6,x0 held while x6 is rewritten
      cyc(1'b1, 32'h00030433, 32'h208, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("stall_rs1_before", bus.out_rs1, 32'hDEADBEEF);
      cyc(1'b1, 32'hFFB00093, 32'h20C, 1'b0, 1'b1, 5'd6, 32'h0000CAFE, 1'b0);
      check("stall_rs1_refresh", bus.out_rs1, 32'h0000CAFE);
      check("stall_rs2", bus.out_rs2, 32'd0);
      check("stall_rd", 32'(bus.out_rd), 32'd8);
      check("stall_pc", bus.out_pc, 32'h208);
      checkb("stall_isreg", bus.out_isALUreg, 1'b1);
      checkb("stall_valid", bus.out_valid, 1'b1);
      checkb("stall_in_ready", bus.in_ready, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      checkb("consume_valid", bus.out_valid, 1'b0);

      // x0 stays zero, both from the array and through the bypass
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h0000FFFF, 1'b0);
      cyc(1'b1, 32'h000004B3, 32'h210, 1'b1, 1'b1, 5'd0, 32'h00001234, 1'b0);
      check("x0_rs1", bus.out_rs1, 32'd0);
      check("x0_rs2", bus.out_rs2, 32'd0);

      // reset while stalled drops the bundle and clears the registers
      cyc(1'b1, 32'h00030433, 32'h214, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      checkb("stall2_valid", bus.out_valid, 1'b1);
      cyc(1'b1, 32'h40310233, 32'h218, 1'b0, 1'b1, 5'd10, 32'h55AA55AA, 1'b1);
      checkb("rst_stall_valid", bus.out_valid, 1'b0);
      check("rst_stall_rd", 32'(bus.out_rd), 32'd0);
      check("rst_stall_rs1", bus.out_rs1, 32'd0);
      checkb("rst_stall_in_ready", bus.in_ready, 1'b1);
      cyc(1'b1, 32'h002505B3, 32'h21C, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      check("post_rst_x10", bus.out_rs1, 32'd0);
      check("post_rst_x2", bus.out_rs2, 32'd0);

      // random traffic with small register indices to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         ins = $urandom;
         sel = $urandom_range(0, 3);
         if (sel < 2) ins[6:0] = 7'h33;
         else if (sel == 2) ins[6:0] = 7'h13;
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         cyc(1'($urandom_range(0, 1)), ins, $urandom,
             ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
